// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer.
//   state_t      : sequencer FSM states
//   PERF_CNT_W   : width of the performance counters
//   FLUSH_CYCLES : wavefront flush depth of a ROWS x COLS array
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int PERF_CNT_W = 32;

  function automatic int FLUSH_CYCLES(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/systolic_phase_counter.sv
// Loadable up-counter with enable, clear and terminal-count compare.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : synchronous clear to 0 (highest priority)
//   i_load       : load i_load_val (second priority)
//   i_en         : count up by one
//   i_term       : terminal value to compare against
//   o_count      : current count
//   o_tc         : o_count == i_term
module systolic_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Multi-tile job sequencer for a ROWS x COLS systolic array. For each tile it
// issues k_len valid cycles (pausable by feed_stall), waits ROWS+COLS-2 cycles
// for the wavefront to flush, then drains ROWS result rows over a
// drain_valid/drain_ready handshake. Supports abort and config checking.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, k_len,
//   num_tiles             : job request and its configuration (latched on accept)
//   abort                 : cancel the running job
//   feed_stall            : input buffer not ready, pauses FEED
//   busy, done, cfg_err,
//   aborted               : job status
//   acc_clear, valid_src,
//   k_idx, tile_idx       : array control
//   drain_valid,
//   drain_ready, drain_row: result drain handshake
//   perf_busy_cycles,
//   perf_stall_cycles     : counters, present only with SYSTOLIC_SEQ_PERF_EN
// Optional feature macro: SYSTOLIC_SEQ_PERF_EN (performance counters).
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_MAX     = 16,
  parameter int MAX_TILES = 64,
  localparam int KLW = $clog2(K_MAX + 1),
  localparam int NTW = $clog2(MAX_TILES + 1),
  localparam int KW  = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int TW  = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KLW-1:0]        k_len,
  input  logic [NTW-1:0]        num_tiles,
  input  logic                  abort,
  input  logic                  feed_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  aborted,
  output logic                  acc_clear,
  output logic                  valid_src,
  output logic [KW-1:0]         k_idx,
  output logic [TW-1:0]         tile_idx,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [RW-1:0]         drain_row,
  output logic [PERF_CNT_W-1:0] perf_busy_cycles,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles
);

  localparam int F          = FLUSH_CYCLES(ROWS, COLS);
  localparam int FW         = (F > 1) ? $clog2(F) : 1;
  localparam int FLUSH_LAST = (F > 0) ? F - 1 : 0;
  localparam bit SKIP_FLUSH = (F == 0);

  state_t         r_state, w_state_nx;
  logic [KLW-1:0] r_k_len;
  logic [NTW-1:0] r_num_tiles;
  logic           r_cfg_err;
  logic           r_aborted;
  logic           r_acc_clear;

  logic           w_busy, w_abort, w_valid, w_cfg_ok;
  logic           w_accept, w_reject;
  logic           w_feed_last, w_flush_last, w_to_drain;
  logic           w_row_last, w_tile_adv, w_job_end;
  logic           w_k_tc, w_flush_tc, w_row_tc, w_tile_tc;
  logic [KW-1:0]  w_k_cnt;
  logic [FW-1:0]  w_flush_cnt;
  logic [RW-1:0]  w_row_cnt;
  logic [TW-1:0]  w_tile_cnt;

  assign w_cfg_ok = (k_len != '0) && (k_len <= KLW'(K_MAX)) &&
                    (num_tiles != '0) && (num_tiles <= NTW'(MAX_TILES));

  assign w_busy   = (r_state == ST_FEED) || (r_state == ST_FLUSH) ||
                    (r_state == ST_DRAIN);
  // Abort only matters while a job is running; it overrides every transition.
  assign w_abort  = abort && w_busy;
  assign w_valid  = (r_state == ST_FEED) && !feed_stall;
  assign w_accept = (r_state == ST_IDLE) && start && w_cfg_ok;
  assign w_reject = (r_state == ST_IDLE) && start && !w_cfg_ok;

  assign w_feed_last  = w_valid && w_k_tc && !abort;
  assign w_flush_last = (r_state == ST_FLUSH) && w_flush_tc && !abort;
  assign w_to_drain   = (w_feed_last && SKIP_FLUSH) || w_flush_last;
  assign w_row_last   = (r_state == ST_DRAIN) && drain_ready && w_row_tc && !abort;
  assign w_tile_adv   = w_row_last && !w_tile_tc;
  assign w_job_end    = w_row_last && w_tile_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)      w_state_nx = ST_FEED;
        else if (w_reject) w_state_nx = ST_DONE;
      end
      ST_FEED: begin
        if (w_abort)          w_state_nx = ST_IDLE;
        else if (w_feed_last) w_state_nx = SKIP_FLUSH ? ST_DRAIN : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_abort)           w_state_nx = ST_IDLE;
        else if (w_flush_last) w_state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_abort)         w_state_nx = ST_IDLE;
        else if (w_job_end)  w_state_nx = ST_DONE;
        else if (w_tile_adv) w_state_nx = ST_FEED;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Config is captured only at accept; cfg_err is remembered until the next
  // accepted job but is only exposed while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_len     <= '0;
      r_num_tiles <= '0;
      r_cfg_err   <= 1'b0;
      r_aborted   <= 1'b0;
      r_acc_clear <= 1'b0;
    end else begin
      r_aborted   <= w_abort;
      r_acc_clear <= w_accept || w_tile_adv;
      if (w_accept) begin
        r_k_len     <= k_len;
        r_num_tiles <= num_tiles;
        r_cfg_err   <= 1'b0;
      end else if (w_reject) begin
        r_cfg_err   <= 1'b1;
      end
    end
  end

  systolic_phase_counter #(.W(KW)) u_k_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept || w_tile_adv || w_abort),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_valid),
    .i_term     (KW'(r_k_len - KLW'(1))),
    .o_count    (w_k_cnt),
    .o_tc       (w_k_tc)
  );

  systolic_phase_counter #(.W(FW)) u_flush_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_feed_last || w_abort),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (r_state == ST_FLUSH),
    .i_term     (FW'(FLUSH_LAST)),
    .o_count    (w_flush_cnt),
    .o_tc       (w_flush_tc)
  );

  systolic_phase_counter #(.W(RW)) u_row_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_to_drain || w_abort),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       ((r_state == ST_DRAIN) && drain_ready),
    .i_term     (RW'(ROWS - 1)),
    .o_count    (w_row_cnt),
    .o_tc       (w_row_tc)
  );

  systolic_phase_counter #(.W(TW)) u_tile_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept || w_abort),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_tile_adv),
    .i_term     (TW'(r_num_tiles - NTW'(1))),
    .o_count    (w_tile_cnt),
    .o_tc       (w_tile_tc)
  );

  assign busy        = w_busy;
  assign done        = (r_state == ST_DONE);
  assign cfg_err     = r_cfg_err && (r_state == ST_DONE);
  assign aborted     = r_aborted;
  assign acc_clear   = r_acc_clear;
  assign valid_src   = w_valid;
  assign k_idx       = w_k_cnt;
  assign tile_idx    = w_tile_cnt;
  assign drain_valid = (r_state == ST_DRAIN);
  assign drain_row   = w_row_cnt;

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [PERF_CNT_W-1:0] r_perf_busy;
  logic [PERF_CNT_W-1:0] r_perf_stall;
  logic                  w_stall;

  assign w_stall = ((r_state == ST_FEED) && feed_stall) ||
                   ((r_state == ST_DRAIN) && !drain_ready);

  // Saturating counters; they hold once the job leaves the busy states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else if (w_accept) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_busy && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + PERF_CNT_W'(1);
      if (w_stall && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + PERF_CNT_W'(1);
    end
  end

  assign perf_busy_cycles  = r_perf_busy;
  assign perf_stall_cycles = r_perf_stall;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

  logic w_unused;
  assign w_unused = ^w_flush_cnt;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: a 4x4 instance and a 1x1 instance
// (no flush phase) driven from a table of job records, plus hand-written
// reset sequences. Cycle 0 is the cycle in which start is sampled.
module tb_systolic_tile_sequencer;

  localparam int LIMIT = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, abort, feed_stall, drain_ready;
  logic [4:0]  k_len;
  logic [6:0]  num_tiles;

  logic        busy0, done0, cfg0, ab0, acc0, vs0, dv0;
  logic [3:0]  k0;
  logic [5:0]  t0;
  logic [1:0]  r0;
  logic [31:0] pb0, ps0;

  logic        busy1, done1, cfg1, ab1, acc1, vs1, dv1;
  logic [3:0]  k1;
  logic [5:0]  t1;
  logic [0:0]  r1;
  logic [31:0] pb1, ps1;

  systolic_tile_sequencer #(.ROWS(4), .COLS(4), .K_MAX(16), .MAX_TILES(64)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .k_len(k_len), .num_tiles(num_tiles),
    .abort(abort), .feed_stall(feed_stall), .busy(busy0), .done(done0),
    .cfg_err(cfg0), .aborted(ab0), .acc_clear(acc0), .valid_src(vs0),
    .k_idx(k0), .tile_idx(t0), .drain_valid(dv0), .drain_ready(drain_ready),
    .drain_row(r0), .perf_busy_cycles(pb0), .perf_stall_cycles(ps0));

  systolic_tile_sequencer #(.ROWS(1), .COLS(1), .K_MAX(16), .MAX_TILES(64)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .k_len(k_len), .num_tiles(num_tiles),
    .abort(abort), .feed_stall(feed_stall), .busy(busy1), .done(done1),
    .cfg_err(cfg1), .aborted(ab1), .acc_clear(acc1), .valid_src(vs1),
    .k_idx(k1), .tile_idx(t1), .drain_valid(dv1), .drain_ready(drain_ready),
    .drain_row(r1), .perf_busy_cycles(pb1), .perf_stall_cycles(ps1));

  typedef struct {
    int dut, k, n, st0, stn, dr0, drn, ab;
    int e_done, e_cfg, e_valid, e_acc2, e_nacc, e_hs, e_abc, e_pb, e_ps;
  } vec_t;

  typedef struct {
    int done_c, cfg, nvalid, acc1, acc2, nacc, hs, abc, nab, ab_busy;
    int busy_seen, maxt, hold_err, pb, ps;
  } res_t;

  int nchk = 0;
  int nerr = 0;

  logic s_busy, s_done, s_cfg, s_ab, s_acc, s_vs, s_dv;
  int   s_k, s_t, s_r, s_pb, s_ps;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample(input int dut);
    if (dut == 0) begin
      s_busy = busy0; s_done = done0; s_cfg = cfg0; s_ab = ab0; s_acc = acc0;
      s_vs = vs0; s_dv = dv0; s_k = int'(k0); s_t = int'(t0); s_r = int'(r0);
      s_pb = int'(pb0); s_ps = int'(ps0);
    end else begin
      s_busy = busy1; s_done = done1; s_cfg = cfg1; s_ab = ab1; s_acc = acc1;
      s_vs = vs1; s_dv = dv1; s_k = int'(k1); s_t = int'(t1); s_r = int'(r1);
      s_pb = int'(pb1); s_ps = int'(ps1);
    end
  endtask

  // Called at a falling edge; runs one job and collects what was observed.
  task automatic run_job(input vec_t v, output res_t r);
    int  end_c;
    bit  pstall, pdv, pdr;
    int  pk, prow;
    r = '{default: 0};
    k_len = 5'(v.k); num_tiles = 7'(v.n);
    abort = (v.ab == 0); feed_stall = 1'b0; drain_ready = 1'b1;
    if (v.dut == 0) start0 = 1'b1; else start1 = 1'b1;
    pstall = 0; pdv = 0; pdr = 1; pk = 0; prow = 0;
    end_c = LIMIT;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      abort       = (c == v.ab);
      feed_stall  = (c >= v.st0) && (c < v.st0 + v.stn);
      drain_ready = !((c >= v.dr0) && (c < v.dr0 + v.drn));
      #1;
      sample(v.dut);
      if (pstall && (s_k != pk)) r.hold_err++;
      if (pdv && !pdr && (s_r != prow)) r.hold_err++;
      pstall = feed_stall && s_busy && !s_dv;
      pdv = s_dv; pdr = drain_ready; pk = s_k; prow = s_r;
      if (s_vs) r.nvalid++;
      if (s_acc) begin
        r.nacc++;
        if (r.nacc == 1) r.acc1 = c;
        if (r.nacc == 2) r.acc2 = c;
      end
      if (s_busy) r.busy_seen = 1;
      if (s_dv && drain_ready) r.hs++;
      if (s_t > r.maxt) r.maxt = s_t;
      if (s_ab) begin
        r.nab++;
        if (r.abc == 0) begin
          r.abc = c; r.ab_busy = int'(s_busy); r.pb = s_pb; r.ps = s_ps;
          end_c = c + 3;
        end
      end
      if (s_done) begin
        r.done_c = c; r.cfg = int'(s_cfg); r.pb = s_pb; r.ps = s_ps;
        break;
      end
    end
    feed_stall = 1'b0; drain_ready = 1'b1; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  localparam int NV = 13;
  vec_t vecs [NV];
  res_t res;
  int   pb_exp, ps_exp, quiet;

  initial begin
    //        dut k  n   st0 stn dr0 drn ab  done cfg val acc2 nacc hs  abc pb  ps
    vecs[0]  = '{0, 4, 2,  0, 0,  0, 0, -1,  29, 0,  8, 15,  2,   8,  0,  28, 0};
    vecs[1]  = '{0, 4, 2,  2, 3, 15, 2, -1,  34, 0,  8, 20,  2,   8,  0,  33, 5};
    vecs[2]  = '{0, 0, 2,  0, 0,  0, 0, -1,   1, 1,  0,  0,  0,   0,  0,  33, 5};
    vecs[3]  = '{0, 4, 65, 0, 0,  0, 0, -1,   1, 1,  0,  0,  0,   0,  0,  33, 5};
    vecs[4]  = '{0, 16, 1, 0, 0,  0, 0, -1,  27, 0, 16,  0,  1,   4,  0,  26, 0};
    vecs[5]  = '{0, 1, 3,  0, 0,  0, 0, -1,  34, 0,  3, 12,  3,  12,  0,  33, 0};
    vecs[6]  = '{0, 17, 1, 0, 0,  0, 0, -1,   1, 1,  0,  0,  0,   0,  0,  33, 0};
    vecs[7]  = '{0, 1, 64, 0, 0,  0, 0, -1, 705, 0, 64, 12, 64, 256,  0, 704, 0};
    vecs[8]  = '{1, 3, 2,  0, 0,  0, 0, -1,   9, 0,  6,  5,  2,   2,  0,   8, 0};
    vecs[9]  = '{1, 1, 1,  0, 0,  0, 0, -1,   3, 0,  1,  0,  1,   1,  0,   2, 0};
    vecs[10] = '{0, 4, 2,  0, 0,  0, 0, 20,   0, 0,  8, 15,  2,   4, 21,  20, 0};
    vecs[11] = '{0, 4, 2,  0, 0,  0, 0,  0,  29, 0,  8, 15,  2,   8,  0,  28, 0};
    vecs[12] = '{1, 2, 2,  1, 1,  4, 1, -1,   9, 0,  4,  6,  2,   2,  0,   8, 2};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    feed_stall = 1'b0; drain_ready = 1'b1; k_len = '0; num_tiles = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs dut0", int'({busy0, done0, cfg0, ab0, acc0, vs0, dv0, k0, t0, r0}), 0);
    chk("reset perf dut0", int'(pb0 | ps0), 0);
    chk("reset outputs dut1", int'({busy1, done1, cfg1, ab1, acc1, vs1, dv1, k1, t1, r1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_job(vecs[i], res);
      chk($sformatf("v%0d done_cycle", i), res.done_c, vecs[i].e_done);
      chk($sformatf("v%0d cfg_err", i), res.cfg, vecs[i].e_cfg);
      chk($sformatf("v%0d valid_count", i), res.nvalid, vecs[i].e_valid);
      chk($sformatf("v%0d acc_clear_first", i), res.acc1, (vecs[i].e_cfg != 0) ? 0 : 1);
      chk($sformatf("v%0d acc_clear_second", i), res.acc2, vecs[i].e_acc2);
      chk($sformatf("v%0d acc_clear_count", i), res.nacc, vecs[i].e_nacc);
      chk($sformatf("v%0d drain_handshakes", i), res.hs, vecs[i].e_hs);
      chk($sformatf("v%0d aborted_cycle", i), res.abc, vecs[i].e_abc);
      chk($sformatf("v%0d aborted_pulses", i), res.nab, (vecs[i].e_abc != 0) ? 1 : 0);
      chk($sformatf("v%0d busy_at_aborted", i), res.ab_busy, 0);
      chk($sformatf("v%0d busy_seen", i), res.busy_seen, (vecs[i].e_cfg != 0) ? 0 : 1);
      chk($sformatf("v%0d stall_hold", i), res.hold_err, 0);
      if (vecs[i].e_cfg == 0)
        chk($sformatf("v%0d max_tile_idx", i), res.maxt, vecs[i].n - 1);
      pb_exp = vecs[i].e_pb;
      ps_exp = vecs[i].e_ps;
`ifndef SYSTOLIC_SEQ_PERF_EN
      pb_exp = 0;
      ps_exp = 0;
`endif
      chk($sformatf("v%0d perf_busy", i), res.pb, pb_exp);
      chk($sformatf("v%0d perf_stall", i), res.ps, ps_exp);
    end

    // Reset asserted mid-job: immediate return to idle, no pulses afterwards.
    k_len = 5'd4; num_tiles = 7'd2; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("midreset busy_before", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset outputs", int'({busy0, done0, cfg0, ab0, acc0, vs0, dv0, k0, t0, r0}), 0);
    chk("midreset perf", int'(pb0 | ps0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (busy0 || done0 || ab0) quiet++;
    end
    chk("midreset no_activity", quiet, 0);
    run_job(vecs[0], res);
    chk("after_reset done_cycle", res.done_c, 29);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
